// File: rtl/divseq_pkg.sv
// Shared state encoding, widths and helpers for divider_sequencer.
package divseq_pkg;

  localparam int DIV_W = 32;
  localparam logic [DIV_W-1:0] IDLE_DIVIDER_DEF = 32'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  // clkdiv with a zero divider would wrap to 2^32-1, so zero is driven as one.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/divseq_table.sv
// Step table for divider_sequencer: one write port, one asynchronous read port.
module divseq_table
  import divseq_pkg::*;
#(
  parameter int NUM_STEPS = 8,
  parameter int DWELL_W   = 16,
  parameter int STEP_W    = $clog2(NUM_STEPS)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_we,
  input  logic [STEP_W-1:0]  i_waddr,
  input  logic [DIV_W-1:0]   i_wdiv,
  input  logic [DWELL_W-1:0] i_wdwell,
  input  logic [STEP_W-1:0]  i_raddr,
  output logic [DIV_W-1:0]   o_rdiv,
  output logic [DWELL_W-1:0] o_rdwell
);

  logic [DIV_W-1:0]   r_div   [NUM_STEPS];
  logic [DWELL_W-1:0] r_dwell [NUM_STEPS];
  logic               w_wr_ok;
  logic               w_rd_ok;

  // Address range checks only exist when the index can exceed the table depth.
  generate
    if (NUM_STEPS == (1 << STEP_W)) begin : g_full
      assign w_wr_ok = 1'b1;
      assign w_rd_ok = 1'b1;
    end else begin : g_part
      localparam logic [STEP_W-1:0] MAX_IDX = STEP_W'(NUM_STEPS - 1);
      assign w_wr_ok = (i_waddr <= MAX_IDX);
      assign w_rd_ok = (i_raddr <= MAX_IDX);
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        r_div[i]   <= 32'd1;
        r_dwell[i] <= DWELL_W'(1'b1);
      end
    end else if (i_we && w_wr_ok) begin
      r_div[i_waddr]   <= i_wdiv;
      r_dwell[i_waddr] <= i_wdwell;
    end
  end

  always_comb begin
    o_rdiv   = 32'd1;
    o_rdwell = DWELL_W'(1'b1);
    if (w_rd_ok) begin
      o_rdiv   = r_div[i_raddr];
      o_rdwell = r_dwell[i_raddr];
    end else begin
      o_rdiv   = 32'd1;
      o_rdwell = DWELL_W'(1'b1);
    end
  end

endmodule

// File: rtl/divider_sequencer.sv
// Drives clkdiv's divider from a (divider, dwell) step table, counting clk_out toggles.
// Define DIVSEQ_PINGPONG_EN to bounce 0..cfg_last..0 instead of wrapping.
module divider_sequencer
  import divseq_pkg::*;
#(
  parameter int               NUM_STEPS    = 8,
  parameter int               DWELL_W      = 16,
  parameter logic [DIV_W-1:0] IDLE_DIVIDER = IDLE_DIVIDER_DEF,
  localparam int              STEP_W       = $clog2(NUM_STEPS)
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               cfg_we,
  input  logic [STEP_W-1:0]  cfg_addr,
  input  logic [DIV_W-1:0]   cfg_divider,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [STEP_W-1:0]  cfg_last,
  input  logic               clk_out_fb,
  output logic [DIV_W-1:0]   divider,
  output logic [STEP_W-1:0]  step_idx,
  output logic               step_strobe,
  output logic               busy
);

  localparam logic [STEP_W-1:0]  IDX_ZERO  = {STEP_W{1'b0}};
  localparam logic [STEP_W-1:0]  IDX_ONE   = STEP_W'(1'b1);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1'b1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_fb_q;
  logic               r_first;
  logic               r_ent;
  logic [DIV_W-1:0]   r_wdiv;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_count;
  logic [STEP_W-1:0]  w_last;
  logic [STEP_W-1:0]  w_adv_idx;
  logic [STEP_W-1:0]  w_rd_idx;
  logic [DIV_W-1:0]   w_tbl_div;
  logic [DWELL_W-1:0] w_tbl_dwell;
  logic               w_tick;
  logic               w_at_end;
  logic               w_start_entry;
  logic               w_resume;
  logic               w_adv;
  logic               w_count_inc;
  logic               w_enter;

  divseq_table #(
    .NUM_STEPS (NUM_STEPS),
    .DWELL_W   (DWELL_W),
    .STEP_W    (STEP_W)
  ) u_table (
    .i_clk    (clk_in),
    .i_rst    (rst),
    .i_we     (cfg_we),
    .i_waddr  (cfg_addr),
    .i_wdiv   (cfg_divider),
    .i_wdwell (cfg_dwell),
    .i_raddr  (w_rd_idx),
    .o_rdiv   (w_tbl_div),
    .o_rdwell (w_tbl_dwell)
  );

  generate
    if (NUM_STEPS == (1 << STEP_W)) begin : g_last_full
      assign w_last = cfg_last;
    end else begin : g_last_sat
      localparam logic [STEP_W-1:0] MAX_IDX = STEP_W'(NUM_STEPS - 1);
      assign w_last = (cfg_last > MAX_IDX) ? MAX_IDX : cfg_last;
    end
  endgenerate

  // The first RUN cycle after entry or resume never counts a toggle.
  assign w_tick   = (r_state == S_RUN) && !r_first && (r_fb_q ^ clk_out_fb);
  assign w_at_end = (r_count == (r_dwell - DWELL_ONE));
  assign w_enter  = w_start_entry | w_adv;
  assign w_rd_idx = w_start_entry ? IDX_ZERO : w_adv_idx;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_fb_q  <= 1'b0;
      r_first <= 1'b0;
      r_ent   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fb_q  <= clk_out_fb;
      r_first <= w_enter | w_resume;
      r_ent   <= w_enter;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_start_entry = 1'b0;
    w_resume      = 1'b0;
    w_adv         = 1'b0;
    w_count_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (start) begin
          w_state_nxt   = S_RUN;
          w_start_entry = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else begin
          // A toggle seen in the pausing cycle is still accounted for.
          w_state_nxt = (pause && !start) ? S_PAUSE : S_RUN;
          w_adv       = w_tick && w_at_end;
          w_count_inc = w_tick && !w_at_end;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (start) begin
          w_state_nxt = S_RUN;
          w_resume    = 1'b1;
        end else begin
          w_state_nxt = S_PAUSE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef DIVSEQ_PINGPONG_EN
  logic r_dir_up;
  logic w_dir_up_nxt;

  always_comb begin
    w_adv_idx    = step_idx;
    w_dir_up_nxt = r_dir_up;
    if (r_dir_up) begin
      if (step_idx >= w_last) begin
        w_dir_up_nxt = 1'b0;
        w_adv_idx    = (step_idx == IDX_ZERO) ? IDX_ZERO : step_idx - IDX_ONE;
      end else begin
        w_adv_idx = step_idx + IDX_ONE;
      end
    end else begin
      if (step_idx == IDX_ZERO) begin
        w_dir_up_nxt = 1'b1;
        w_adv_idx    = (w_last == IDX_ZERO) ? IDX_ZERO : IDX_ONE;
      end else begin
        w_adv_idx = step_idx - IDX_ONE;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_dir_up <= 1'b1;
    end else if (w_start_entry) begin
      r_dir_up <= 1'b1;
    end else if (w_adv) begin
      r_dir_up <= w_dir_up_nxt;
    end
  end
`else
  always_comb begin
    w_adv_idx = IDX_ZERO;
    if (step_idx >= w_last) begin
      w_adv_idx = IDX_ZERO;
    end else begin
      w_adv_idx = step_idx + IDX_ONE;
    end
  end
`endif

  // Working copy of the active entry; table writes land here only on re-entry.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      step_idx <= IDX_ZERO;
      r_wdiv   <= 32'd1;
      r_dwell  <= DWELL_ONE;
      r_count  <= {DWELL_W{1'b0}};
    end else if (w_state_nxt == S_IDLE) begin
      step_idx <= IDX_ZERO;
      r_count  <= {DWELL_W{1'b0}};
    end else if (w_enter) begin
      step_idx <= w_rd_idx;
      r_wdiv   <= clamp_div(w_tbl_div);
      r_dwell  <= (w_tbl_dwell == {DWELL_W{1'b0}}) ? DWELL_ONE : w_tbl_dwell;
      r_count  <= {DWELL_W{1'b0}};
    end else if (w_count_inc) begin
      r_count <= r_count + DWELL_ONE;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      divider     <= IDLE_DIVIDER;
      step_strobe <= 1'b0;
      busy        <= 1'b0;
    end else begin
      busy        <= (w_state_nxt != S_IDLE);
      step_strobe <= r_ent && (w_state_nxt != S_IDLE);
      if (w_state_nxt == S_IDLE) begin
        divider <= IDLE_DIVIDER;
      end else if (r_ent) begin
        divider <= r_wdiv;
      end
    end
  end

endmodule

// File: tb/tb_divider_sequencer.sv
// Self-checking bench for divider_sequencer with a behavioural clkdiv in the loop
// (clk_out toggles every 2*divider clk_in cycles). Honours DIVSEQ_PINGPONG_EN.
module tb_divider_sequencer;

  typedef struct {
    int step;
    int div;
    int tog;
  } ev_t;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = 3'd0;
  logic [31:0] cfg_divider = 32'd0;
  logic [15:0] cfg_dwell = 16'd0;
  logic [2:0]  cfg_last = 3'd0;
  logic        clk_out;
  logic [31:0] divider;
  logic [2:0]  step_idx;
  logic        step_strobe;
  logic        busy;

  int  n_checks = 0;
  int  n_err = 0;
  ev_t ev_q[$];
  ev_t exp_q[$];
  logic mon_prev = 1'b0;
  bit  mon_tog = 1'b0;
  bit  counting = 1'b1;
  int  win_cnt = 0;
  logic [31:0] m_cnt;

  always #5 clk_in = ~clk_in;

  divider_sequencer #(
    .NUM_STEPS    (8),
    .DWELL_W      (16),
    .IDLE_DIVIDER (32'd1)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_divider (cfg_divider),
    .cfg_dwell   (cfg_dwell),
    .cfg_last    (cfg_last),
    .clk_out_fb  (clk_out),
    .divider     (divider),
    .step_idx    (step_idx),
    .step_strobe (step_strobe),
    .busy        (busy)
  );

  // Behavioural clkdiv: half period of 2*divider input clocks.
  always @(posedge clk_in or posedge rst) begin
    if (rst) begin
      m_cnt   <= 32'd0;
      clk_out <= 1'b0;
    end else if ((m_cnt + 32'd1) >= (divider << 1)) begin
      m_cnt   <= 32'd0;
      clk_out <= ~clk_out;
    end else begin
      m_cnt <= m_cnt + 32'd1;
    end
  end

  // Records every step entry with the toggles seen during the previous step.
  always @(negedge clk_in) begin : mon
    ev_t e;
    mon_tog  = (clk_out !== mon_prev);
    mon_prev = clk_out;
    if (step_strobe === 1'b1) begin
      e.step = int'(step_idx);
      e.div  = int'(divider);
      e.tog  = win_cnt;
      ev_q.push_back(e);
      win_cnt = (mon_tog && counting) ? 1 : 0;
    end else if (mon_tog && counting) begin
      win_cnt++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk_in);
      #1;
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cfg_write(input int a, input int d, input int w);
    cfg_addr    = 3'(a);
    cfg_divider = 32'(d);
    cfg_dwell   = 16'(w);
    cfg_we      = 1'b1;
    tick(1);
    cfg_we      = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic stop_and_clear();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(2);
    ev_q.delete();
    exp_q.delete();
    win_cnt  = 0;
    counting = 1'b1;
  endtask

  task automatic add_exp(input int s, input int d, input int t);
    ev_t e;
    e.step = s;
    e.div  = d;
    e.tog  = t;
    exp_q.push_back(e);
  endtask

  task automatic wait_events(input string name, input int n);
    int k = 0;
    while (ev_q.size() < n && k < 2000) begin
      tick(1);
      k++;
    end
    chk({name, ".events"}, (ev_q.size() >= n) ? n : ev_q.size(), n);
  endtask

  task automatic run_vectors(input string name);
    wait_events(name, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < ev_q.size()) begin
        chk($sformatf("%s[%0d].step", name, i), ev_q[i].step, exp_q[i].step);
        chk($sformatf("%s[%0d].div", name, i), ev_q[i].div, exp_q[i].div);
        if (exp_q[i].tog >= 0) begin
          chk($sformatf("%s[%0d].toggles", name, i), ev_q[i].tog, exp_q[i].tog);
        end
      end
    end
  endtask

  initial begin
    int k;
    // Reset values
    tick(3);
    chk("rst.divider", divider, 1);
    chk("rst.step_idx", step_idx, 0);
    chk("rst.busy", busy, 0);
    chk("rst.strobe", step_strobe, 0);
    rst = 1'b0;
    tick(2);

    // Two-step wrap with cycle-exact entry latency
    cfg_write(0, 4, 2);
    cfg_write(1, 2, 3);
    cfg_last = 3'd1;
    ev_q.delete();
    win_cnt = 0;
    pulse_start();
    chk("start.busy", busy, 1);
    chk("start.div_not_yet", divider, 1);
    chk("start.strobe_not_yet", step_strobe, 0);
    tick(1);
    chk("entry.strobe", step_strobe, 1);
    chk("entry.div", divider, 4);
    chk("entry.step", step_idx, 0);
    tick(1);
    chk("entry.strobe_one_cycle", step_strobe, 0);
    add_exp(0, 4, -1);
    add_exp(1, 2, 2);
    add_exp(0, 4, 3);
    add_exp(1, 2, 2);
    add_exp(0, 4, 3);
    run_vectors("wrap");

    // Zero divider/dwell entry and wrap vs ping-pong order
    stop_and_clear();
    chk("stop.busy", busy, 0);
    chk("stop.divider", divider, 1);
    chk("stop.step", step_idx, 0);
    cfg_write(2, 0, 0);
    cfg_last = 3'd2;
    add_exp(0, 4, -1);
    add_exp(1, 2, 2);
    add_exp(2, 1, 3);
`ifdef DIVSEQ_PINGPONG_EN
    add_exp(1, 2, 1);
    add_exp(0, 4, 3);
    add_exp(1, 2, 2);
`else
    add_exp(0, 4, 1);
    add_exp(1, 2, 2);
`endif
    pulse_start();
    run_vectors("order");

    // Pause at step 1 after one toggle, resume finishes the remaining two
    stop_and_clear();
    cfg_last = 3'd1;
    pulse_start();
    wait_events("pause", 2);
    k = 0;
    while (win_cnt < 1 && k < 200) begin
      tick(1);
      k++;
    end
    chk("pause.first_toggle", win_cnt, 1);
    tick(1);
    pause    = 1'b1;
    counting = 1'b0;
    tick(1);
    pause = 1'b0;
    tick(50);
    chk("pause.busy", busy, 1);
    chk("pause.step", step_idx, 1);
    chk("pause.divider", divider, 2);
    chk("pause.no_strobe", ev_q.size(), 2);
    k = 0;
    do begin
      tick(1);
      k++;
    end while (!mon_tog && k < 200);
    chk("pause.resume_sync", mon_tog, 1);
    start    = 1'b1;
    counting = 1'b1;
    tick(1);
    start = 1'b0;
    chk("resume.busy", busy, 1);
    tick(1);
    chk("resume.no_strobe", step_strobe, 0);
    wait_events("resume", 3);
    if (ev_q.size() >= 3) begin
      chk("resume.next_step", ev_q[2].step, 0);
      chk("resume.toggles", ev_q[2].tog, 3);
    end

    // start+stop together in IDLE, live rewrite of the active entry
    stop_and_clear();
    start = 1'b1;
    stop  = 1'b1;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop.busy", busy, 0);
    tick(3);
    chk("startstop.busy_hold", busy, 0);
    chk("startstop.no_strobe", ev_q.size(), 0);
    pulse_start();
    wait_events("live", 1);
    cfg_write(0, 6, 4);
    chk("live.div_holds", divider, 4);
    add_exp(0, 4, -1);
    add_exp(1, 2, 2);
    add_exp(0, 6, 3);
    add_exp(1, 2, 4);
    run_vectors("live");

    // Asynchronous reset mid-run, then the cleared table reads (1,1)
    tick(3);
    rst = 1'b1;
    #1;
    chk("arst.divider", divider, 1);
    chk("arst.step", step_idx, 0);
    chk("arst.busy", busy, 0);
    chk("arst.strobe", step_strobe, 0);
    tick(1);
    rst = 1'b0;
    tick(2);
    ev_q.delete();
    exp_q.delete();
    win_cnt  = 0;
    cfg_last = 3'd0;
    add_exp(0, 1, -1);
    add_exp(0, 1, 1);
    add_exp(0, 1, 1);
    pulse_start();
    run_vectors("cleared");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
